// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: loader state encoding, bus widths and the
// opcode constants used to assemble program images.
package sap1_pkg;

    localparam int SAP1_ADDR_W = 4;
    localparam int SAP1_DATA_W = 8;

    // Loader sequencing states; CHECK and ERROR are only reachable in the
    // checksum build.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        RELEASE,
        RUN,
        ERROR
    } ldr_state_t;

    // SAP-1 opcodes (upper nibble of an instruction byte).
    localparam logic [3:0] LDA = 4'h0;
    localparam logic [3:0] ADD = 4'h1;
    localparam logic [3:0] SUB = 4'h2;
    localparam logic [3:0] OUT = 4'hE;
    localparam logic [3:0] HLT = 4'hF;

    // Pack an opcode and its 4-bit operand into one program byte.
    function automatic logic [7:0] sap1_instr(input logic [3:0] op, input logic [3:0] arg);
        return {op, arg};
    endfunction

endpackage

// File: rtl/sap1_rst_pulse.sv
// Down-counter that produces a CYCLES-wide reset pulse starting the cycle
// after 'trigger', and flags the final cycle of that pulse.
module sap1_rst_pulse #(
    parameter int CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic trigger,
    output logic pulse,
    output logic expire
);

    localparam int            CW       = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(CYCLES);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] cnt;

    // Load on trigger, then count down to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (trigger) begin
            cnt <= LOAD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end

    assign pulse  = (cnt != '0);
    assign expire = (cnt == ONE);

endmodule

// File: rtl/sap1_prog_loader.sv
// SAP-1 program loader: streams host bytes into the 16x8 program SRAM from
// address 0, holds the CPU in reset while loading, then releases it with a
// clean RST_CYCLES-wide reset pulse.
// Build option: define SAP1_LDR_CHKSUM_EN to accept a trailing checksum
// byte (8-bit sum of all bytes must be zero) and enable CHECK/ERROR states.
module sap1_prog_loader
    import sap1_pkg::*;
#(
    parameter int ADDR_W     = SAP1_ADDR_W,
    parameter int DATA_W     = SAP1_DATA_W,
    parameter int PROG_LEN   = 16,
    parameter int RST_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    // One extra count bit so a full 2**ADDR_W image terminates cleanly.
    localparam int CNT_W = ADDR_W + 1;

`ifdef SAP1_LDR_CHKSUM_EN
    localparam int N_BYTES = PROG_LEN + 1;
`else
    localparam int N_BYTES = PROG_LEN;
`endif

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BYTES - 1);
    localparam logic [CNT_W-1:0] WR_LIMIT = CNT_W'(PROG_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ldr_state_t       state, state_nxt;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             wr_fire;
    logic             last_byte;
    logic             start_load;
    logic             rel_first;
    logic             rst_pulse;
    logic             rst_expire;

    // Acceptance is derived from the state directly so it never depends on
    // the combinational ld_ready output.
    assign accept     = ld_valid && (state == LOAD);
    assign wr_fire    = accept && (count < WR_LIMIT);
    assign last_byte  = accept && (count == LAST_IDX);
    assign start_load = ld_start && (state == IDLE || state == RUN || state == ERROR);

`ifdef SAP1_LDR_CHKSUM_EN
    logic [DATA_W-1:0] sum;

    // Running modular sum of every accepted byte, checksum included.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum <= '0;
        end else if (start_load) begin
            sum <= '0;
        end else if (accept) begin
            sum <= sum + ld_data;
        end
    end
`endif

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore outputs.
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        ld_ready  = 1'b0;
        cpu_rst   = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                if (ld_start) state_nxt = LOAD;
            end
            LOAD: begin
                ld_ready = 1'b1;
`ifdef SAP1_LDR_CHKSUM_EN
                if (last_byte) state_nxt = CHECK;
`else
                if (last_byte) state_nxt = RELEASE;
`endif
            end
`ifdef SAP1_LDR_CHKSUM_EN
            CHECK: begin
                state_nxt = (sum == '0) ? RELEASE : ERROR;
            end
            ERROR: begin
                err = 1'b1;
                if (ld_start) state_nxt = LOAD;
            end
`endif
            RELEASE: begin
                // Held through the last-write cycle, then for the pulse.
                cpu_rst = rel_first | rst_pulse;
                if (rst_expire) state_nxt = RUN;
            end
            RUN: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
                if (ld_start) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Byte counter and one-cycle-delayed SRAM write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rel_first <= 1'b0;
        end else begin
            mem_we    <= wr_fire;
            rel_first <= (state != RELEASE) && (state_nxt == RELEASE);
            if (start_load) begin
                count <= '0;
            end else if (accept) begin
                count <= count + CNT_ONE;
            end
            if (wr_fire) begin
                mem_addr  <= count[ADDR_W-1:0];
                mem_wdata <= ld_data;
            end
        end
    end

    // Pulse starts the cycle after entering RELEASE and lasts RST_CYCLES.
    sap1_rst_pulse #(
        .CYCLES (RST_CYCLES)
    ) u_rst_pulse (
        .clk     (clk),
        .rst     (rst),
        .trigger (rel_first),
        .pulse   (rst_pulse),
        .expire  (rst_expire)
    );

endmodule

// File: tb/tb_sap1_prog_loader.sv
// Scoreboard bench for sap1_prog_loader: PROG_LEN=16 main instance plus a
// PROG_LEN=1 instance for the single-byte edge case.
module tb_sap1_prog_loader;
    import sap1_pkg::*;

    localparam int PL = 16;
    localparam int RC = 2;
`ifdef SAP1_LDR_CHKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic       clk;
    logic       rst;
    logic       ld_start, ld_valid, ld_ready, mem_we, cpu_rst, done, err;
    logic [7:0] ld_data, mem_wdata;
    logic [3:0] mem_addr;

    logic       ld_start1, ld_valid1, ld_ready1, mem_we1, cpu_rst1, done1, err1;
    logic [7:0] ld_data1, mem_wdata1;
    logic [3:0] mem_addr1;

    sap1_prog_loader #(.ADDR_W(4), .DATA_W(8), .PROG_LEN(PL), .RST_CYCLES(RC)) u_dut (
        .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst), .done(done), .err(err)
    );

    sap1_prog_loader #(.ADDR_W(4), .DATA_W(8), .PROG_LEN(1), .RST_CYCLES(RC)) u_dut1 (
        .clk(clk), .rst(rst), .ld_start(ld_start1), .ld_valid(ld_valid1), .ld_data(ld_data1),
        .ld_ready(ld_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .cpu_rst(cpu_rst1), .done(done1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int wr_idx   = 0;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;

    wr_t        sb_q[$];
    logic [7:0] img[PL];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every mem_we must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (mem_we) begin
            if (sb_q.size() == 0) begin
                check("sb_extra_write", {28'd0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("wr_addr", {28'd0, mem_addr}, {28'd0, e.addr});
                check("wr_data", {24'd0, mem_wdata}, {24'd0, e.data});
                check("wr_latency", cyc, e.cyc);
            end
        end
    end

    // Present one byte and hold it until accepted; queue the expected write.
    task automatic send_byte(input logic [7:0] b, input bit is_chk);
        int  w;
        wr_t e;
        ld_valid = 1'b1;
        ld_data  = b;
        w        = 0;
        @(negedge clk);
        while (!ld_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!ld_ready) begin
            check("ready_timeout", {31'd0, ld_ready}, 32'd1);
        end else if (!is_chk) begin
            e.addr = wr_idx[3:0];
            e.data = b;
            e.cyc  = cyc + 1;
            sb_q.push_back(e);
            wr_idx++;
        end
        @(posedge clk);
        #1;
    endtask

    // One-cycle start request, optionally with a byte already presented.
    task automatic start_load(input bit with_valid, input logic [7:0] b);
        ld_start = 1'b1;
        ld_valid = with_valid;
        ld_data  = b;
        wr_idx   = 0;
        @(negedge clk);
        check("ready_at_start", {31'd0, ld_ready}, 32'd0);
        @(posedge clk);
        #1;
        ld_start = 1'b0;
    endtask

    // Stream img[] with 'gap' idle cycles between bytes, plus checksum byte.
    task automatic send_image(input int gap, input bit poke_start, input bit bad_chk);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < PL; i++) begin
            send_byte(img[i], 1'b0);
            s = s + img[i];
            if (gap > 0 && i != PL - 1) begin
                ld_valid = 1'b0;
                if (poke_start && i == 3) ld_start = 1'b1;
                @(posedge clk);
                #1;
                ld_start = 1'b0;
                repeat (gap - 1) @(posedge clk);
                #1;
            end
        end
`ifdef SAP1_LDR_CHKSUM_EN
        send_byte(8'(8'h00 - s) + {7'd0, bad_chk}, 1'b1);
`else
        if (bad_chk) ld_data = s;
`endif
        ld_valid = 1'b0;
    endtask

    // After the final acceptance: CPU held, then released with done=1.
    task automatic wait_release();
        repeat (RC + 1 + EXTRA) begin
            @(negedge clk);
            check("rel_cpu_rst", {31'd0, cpu_rst}, 32'd1);
            check("rel_done", {31'd0, done}, 32'd0);
        end
        @(negedge clk);
        check("run_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        check("run_done", {31'd0, done}, 32'd1);
        check("run_err", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
        ld_start1 = 1'b0; ld_valid1 = 1'b0; ld_data1 = 8'h00;

        // Asynchronous reset state, before any clock edge.
        #2;
        check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_ready", {31'd0, ld_ready}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", {28'd0, mem_addr}, 32'd0);
        check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("idle_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("idle_ready", {31'd0, ld_ready}, 32'd0);
        @(posedge clk);
        #1;

        // Basic back-to-back load; first byte presented with the start.
        img = '{sap1_instr(LDA, 4'h9), sap1_instr(ADD, 4'hA), sap1_instr(OUT, 4'h0),
                sap1_instr(HLT, 4'h0), 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h10, 8'h14, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        start_load(1'b1, img[0]);
        send_image(0, 1'b0, 1'b0);
        wait_release();

        // Reload from RUN, then a gapped handshake with a stray ld_start.
        start_load(1'b0, 8'h00);
        @(negedge clk);
        check("reload_done", {31'd0, done}, 32'd0);
        check("reload_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("reload_ready", {31'd0, ld_ready}, 32'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < PL; i++) img[i] = 8'((i * 7 + 3) ^ 8'h5A);
        send_image(2, 1'b1, 1'b0);
        wait_release();

        // Reset in the middle of a load drops the pending write.
        for (int i = 0; i < PL; i++) img[i] = 8'($urandom_range(0, 255));
        start_load(1'b0, 8'h00);
        for (int i = 0; i < 5; i++) send_byte(img[i], 1'b0);
        rst = 1'b0;
        ld_valid = 1'b0;
        sb_q.delete();
        #1;
        check("midrst_we", {31'd0, mem_we}, 32'd0);
        check("midrst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_ready", {31'd0, ld_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'd0, ld_ready}, 32'd0);
        @(posedge clk);
        #1;
        start_load(1'b0, 8'h00);
        send_image(0, 1'b0, 1'b0);
        wait_release();

`ifdef SAP1_LDR_CHKSUM_EN
        // Bad checksum lands in ERROR with the CPU still held.
        start_load(1'b0, 8'h00);
        send_image(0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("chk_err", {31'd0, err}, 32'd1);
        check("chk_err_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("chk_err_done", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        check("chk_err_hold", {31'd0, err}, 32'd1);
        @(posedge clk);
        #1;
        start_load(1'b0, 8'h00);
        @(negedge clk);
        check("chk_err_clear", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;
        send_image(0, 1'b0, 1'b0);
        wait_release();
`endif

        // PROG_LEN=1 instance: single byte to address 0, then release.
        ld_start1 = 1'b1;
        @(posedge clk);
        #1;
        ld_start1 = 1'b0;
        ld_valid1 = 1'b1;
        ld_data1  = sap1_instr(HLT, 4'h0);
        @(negedge clk);
        check("p1_ready", {31'd0, ld_ready1}, 32'd1);
        @(posedge clk);
        #1;
`ifdef SAP1_LDR_CHKSUM_EN
        ld_data1 = 8'h10;
`else
        ld_valid1 = 1'b0;
`endif
        @(negedge clk);
        check("p1_we", {31'd0, mem_we1}, 32'd1);
        check("p1_addr", {28'd0, mem_addr1}, 32'd0);
        check("p1_data", {24'd0, mem_wdata1}, 32'hF0);
        check("p1_ready_after", {31'd0, ld_ready1}, {31'd0, EXTRA[0]});
`ifdef SAP1_LDR_CHKSUM_EN
        @(posedge clk);
        #1;
        ld_valid1 = 1'b0;
        @(negedge clk);
        check("p1_chk_no_write", {31'd0, mem_we1}, 32'd0);
        check("p1_chk_ready", {31'd0, ld_ready1}, 32'd0);
`endif
        repeat (RC + EXTRA) begin
            @(negedge clk);
            check("p1_rel_cpu_rst", {31'd0, cpu_rst1}, 32'd1);
        end
        @(negedge clk);
        check("p1_run_cpu_rst", {31'd0, cpu_rst1}, 32'd0);
        check("p1_run_done", {31'd0, done1}, 32'd1);

        repeat (2) @(posedge clk);
        check("sb_drain", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
